// File: rtl/hazard_detection_unit_pkg.sv
// Shared state encodings, constants and the load-use match
// for the pipeline hazard controller.
package hazard_detection_unit_pkg;

  typedef enum logic [1:0] {
    HDU_RUN      = 2'd0,
    HDU_MEM_WAIT = 2'd1,
    HDU_HALTED   = 2'd2
  } hdu_state_e;

  localparam logic [4:0] ZERO = 5'd0;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return mem_read && (rd != ZERO) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// 32-bit saturating event counter with enable,
// cleared by asynchronous reset.
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Advance on enable, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall / bubble / flush / freeze controller beside ID.
// Perf counters built only with HAZARD_PERF_CNT_EN.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_RegisterRs1,
  input  logic [4:0]  IF_ID_RegisterRs2,
  input  logic        IF_ID_UsesRs2,
  input  logic [4:0]  ID_EX_RegisterRd,
  input  logic        ID_EX_MemRead,
  input  logic        EX_MEM_MemAccess,
  input  logic        mem_ready,
  input  logic        branch_taken,
  input  logic        halt_req,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        flush,
  output logic        freeze,
  output logic        halted,
  output logic        mem_error,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [8:0] TMO = 9'(MEM_TIMEOUT);

  hdu_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       mem_pend;
  logic       lu_hit;
  logic [8:0] wait_nx;

  assign mem_pend = EX_MEM_MemAccess && !mem_ready;
  assign lu_hit   = load_use(ID_EX_MemRead,
                             ID_EX_RegisterRd,
                             IF_ID_RegisterRs1,
                             IF_ID_RegisterRs2,
                             IF_ID_UsesRs2);
  assign wait_nx  = {1'b0, wait_q} + 9'd1;

  // Next state and all pipeline controls, by priority.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    err_d        = err_q;
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_Bubble = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      freeze = 1'b1;
    end else begin
      unique case (state_q)
        HDU_HALTED: begin
          freeze = 1'b1;
          halted = 1'b1;
        end
        default: begin
          if (halt_req) begin
            freeze  = 1'b1;
            state_d = HDU_HALTED;
          end else if (mem_pend) begin
            freeze = 1'b1;
            if (wait_nx >= TMO) begin
              err_d   = 1'b1;
              state_d = HDU_HALTED;
            end else begin
              wait_d  = wait_nx[7:0];
              state_d = HDU_MEM_WAIT;
            end
          end else if (branch_taken) begin
            flush       = 1'b1;
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            state_d     = HDU_RUN;
          end else if (lu_hit) begin
            ID_EX_Bubble = 1'b1;
            state_d      = HDU_RUN;
          end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            state_d     = HDU_RUN;
          end
        end
      endcase
    end
  end

  // State, wait counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDU_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign mem_error = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_en;
  assign stall_en = !rst && (state_q != HDU_HALTED) &&
                    (freeze || ID_EX_Bubble);

  sat_counter u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (stall_en),
    .count_o (stall_cycles)
  );

  sat_counter u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (flush),
    .count_o (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit
// (instantiated with MEM_TIMEOUT = 4).
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1, rs2, rd;
  logic        uses2, mrd, acc, rdy, br, hreq;
  logic        pcw, ifw, bub, fl, frz, hlt, err;
  logic [31:0] stall_cycles, flush_count;

  typedef struct packed {
    logic pcw, ifw, bub, fl, frz, hlt, err;
  } outs_t;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr, acc, rdy, br, hr;
  } stim_t;

  localparam outs_t NORM  = 7'b1100000;
  localparam outs_t STALL = 7'b0010000;
  localparam outs_t FLUSH = 7'b1101000;
  localparam outs_t FRZ   = 7'b0000100;
  localparam outs_t HALTO = 7'b0000110;
  localparam outs_t HERR  = 7'b0000111;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int    n_cmp = 0;
  int    n_bad = 0;
  outs_t exp_q[$];

  hazard_detection_unit #(.MEM_TIMEOUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_RegisterRs1 (rs1),
    .IF_ID_RegisterRs2 (rs2),
    .IF_ID_UsesRs2     (uses2),
    .ID_EX_RegisterRd  (rd),
    .ID_EX_MemRead     (mrd),
    .EX_MEM_MemAccess  (acc),
    .mem_ready         (rdy),
    .branch_taken      (br),
    .halt_req          (hreq),
    .PC_Write          (pcw),
    .IF_ID_Write       (ifw),
    .ID_EX_Bubble      (bub),
    .flush             (fl),
    .freeze            (frz),
    .halted            (hlt),
    .mem_error         (err),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(
    input int a, input int b, input bit u,
    input int d, input bit m, input bit ac,
    input bit ry, input bit bt, input bit h);
    stim_t s;
    s.rs1 = 5'(a); s.rs2 = 5'(b); s.u2 = u;
    s.rd = 5'(d); s.mr = m; s.acc = ac;
    s.rdy = ry; s.br = bt; s.hr = h;
    return s;
  endfunction

  function automatic outs_t obs();
    return {pcw, ifw, bub, fl, frz, hlt, err};
  endfunction

  // Drive one cycle of inputs and record what must come out.
  task automatic drive(input stim_t s, input outs_t e);
    @(negedge clk);
    rs1 = s.rs1; rs2 = s.rs2; uses2 = s.u2;
    rd = s.rd; mrd = s.mr; acc = s.acc;
    rdy = s.rdy; br = s.br; hreq = s.hr;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic test_reset(input string tag);
    outs_t e, o;
    drive(S(1,2,1,3,0,0,1,0,0), FRZ);
    rst = 1'b1;
    #1;
    e = exp_q.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s outs got=%b want=%b", tag, o, e);
    end
    n_cmp++;
    if ((stall_cycles | flush_count) !== 32'd0) begin
      n_bad++;
      $display("FAIL %s cnt got=%0d/%0d want=0/0",
               tag, stall_cycles, flush_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t s[6];
    outs_t e[6];
    outs_t x, o;
    s[0] = S(5,2,1,5,1,0,1,0,0); e[0] = STALL;
    s[1] = S(5,2,1,5,0,0,1,0,0); e[1] = NORM;
    s[2] = S(0,2,1,0,1,0,1,0,0); e[2] = NORM;
    s[3] = S(1,7,0,7,1,0,1,0,0); e[3] = NORM;
    s[4] = S(1,7,1,7,1,0,1,0,0); e[4] = STALL;
    s[5] = S(1,2,1,9,1,0,1,0,0); e[5] = NORM;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, o, x);
      end
    end
  endtask

  task automatic test_mem_wait();
    outs_t x, o;
    logic [31:0] want;
    test_reset("reset_mw");
    for (int i = 0; i < 5; i++) begin
      if (i < 3)      drive(S(1,2,1,3,0,1,0,0,0), FRZ);
      else if (i == 3) drive(S(1,2,1,3,0,1,1,0,0), NORM);
      else            drive(S(1,2,1,3,0,0,1,0,0), NORM);
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL mem_wait[%0d] got=%b want=%b", i, o, x);
      end
    end
    want = PERF ? 32'd3 : 32'd0;
    n_cmp++;
    if (stall_cycles !== want) begin
      n_bad++;
      $display("FAIL mem_wait_stalls got=%0d want=%0d",
               stall_cycles, want);
    end
  endtask

  task automatic test_priority();
    outs_t x, o;
    logic [31:0] want;
    test_reset("reset_pri");
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(S(5,2,1,5,1,0,1,1,0), FLUSH);
        1: drive(S(1,2,1,3,0,1,0,1,0), FRZ);
        2: drive(S(5,2,1,5,1,1,1,0,0), STALL);
        default: drive(S(1,2,1,3,0,0,1,0,0), NORM);
      endcase
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL priority[%0d] got=%b want=%b", i, o, x);
      end
    end
    want = PERF ? 32'd1 : 32'd0;
    n_cmp++;
    if (flush_count !== want) begin
      n_bad++;
      $display("FAIL flush_count got=%0d want=%0d",
               flush_count, want);
    end
  endtask

  task automatic test_timeout();
    outs_t x, o;
    test_reset("reset_to");
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(S(1,2,1,3,0,1,0,0,0), FRZ);
      else       drive(S(5,2,1,5,1,1,1,1,0), HERR);
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL timeout[%0d] got=%b want=%b", i, o, x);
      end
    end
  endtask

  task automatic test_halt();
    outs_t x, o;
    logic [31:0] want;
    test_reset("reset_halt");
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(S(1,2,1,3,0,0,1,0,1), FRZ);
      else        drive(S(1,2,1,3,0,0,1,1,0), HALTO);
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL halt[%0d] got=%b want=%b", i, o, x);
      end
    end
    want = PERF ? 32'd1 : 32'd0;
    n_cmp++;
    if ((stall_cycles !== want) || (flush_count !== 32'd0)) begin
      n_bad++;
      $display("FAIL halt_cnt got=%0d/%0d want=%0d/0",
               stall_cycles, flush_count, want);
    end
  endtask

  task automatic test_reset_mid_wait();
    outs_t x, o;
    test_reset("reset_rmw");
    for (int i = 0; i < 2; i++) begin
      drive(S(1,2,1,3,0,1,0,0,0), FRZ);
      x = exp_q.pop_front(); o = obs(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL rmw_wait[%0d] got=%b want=%b", i, o, x);
      end
    end
    test_reset("rmw_reset");
    drive(S(1,2,1,3,0,0,1,0,0), NORM);
    x = exp_q.pop_front(); o = obs(); n_cmp++;
    if (o !== x) begin
      n_bad++;
      $display("FAIL rmw_after got=%b want=%b", o, x);
    end
    n_cmp++;
    if ((stall_cycles | flush_count) !== 32'd0) begin
      n_bad++;
      $display("FAIL rmw_cnt got=%0d/%0d want=0/0",
               stall_cycles, flush_count);
    end
  endtask

  initial begin
    {rs1, rs2, rd} = '0;
    {uses2, mrd, acc, br, hreq} = '0;
    rdy = 1'b1;
    test_reset("reset");
    test_load_use();
    test_mem_wait();
    test_priority();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
